// File: rtl/riscv_multicycle_ctrl.sv
// riscv_multicycle_ctrl: control FSM for a multicycle RV32I datapath that
// shares one ALU and one unified instruction/data memory port. It sequences
// fetch, decode, execute, memory and writeback for R/I-ALU, LW, SW, BEQ, JAL, LUI.
// Optional build macro MC_CTRL_PERF_EN adds the cycle and retired-instruction
// performance counters. Without it both counter outputs are tied to 0.
module riscv_multicycle_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned PERF_W         = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [6:0]        opcode,
  input  logic              zero,
  input  logic              mem_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic              addr_src,
  output logic              ir_write,
  output logic              pc_write,
  output logic              pc_write_cond,
  output logic              reg_write,
  output logic [1:0]        result_src,
  output logic [1:0]        alu_src_a,
  output logic [1:0]        alu_src_b,
  output logic [1:0]        alu_op,
  output logic [3:0]        state,
  output logic              retire,
  output logic              illegal,
  output logic              timeout,
  output logic [PERF_W-1:0] cycle_cnt,
  output logic [PERF_W-1:0] instret_cnt
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,  S_DECODE = 4'd1,  S_MEMADDR = 4'd2,  S_MEMREAD = 4'd3,
    S_MEMWB    = 4'd4,  S_MEMWRITE = 4'd5, S_EXEC_R = 4'd6,  S_EXEC_I  = 4'd7,
    S_ALUWB    = 4'd8,  S_BRANCH = 4'd9,  S_JAL     = 4'd10, S_LUI     = 4'd11,
    S_TRAP     = 4'd12
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // Wait counter only needs to reach TIMEOUT_CYCLES-1 before trapping.
  localparam bit              TO_EN     = (TIMEOUT_CYCLES != 0);
  localparam int unsigned     WAIT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

  // Moore part of the control word; registered from the next state so the
  // outputs come straight from flops.
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       addr_src;
    logic       pc_write;
    logic       pc_write_cond;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       retire;
  } ctrl_t;

  function automatic ctrl_t ctrl_of(input state_e st);
    ctrl_t c;
    c = '0;
    case (st)
      S_FETCH:    begin c.mem_req = 1'b1; c.alu_src_b = 2'b10; end
      S_DECODE:   begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; end
      S_MEMADDR:  begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; end
      S_MEMREAD:  begin c.mem_req = 1'b1; c.addr_src = 1'b1; end
      S_MEMWB:    begin c.reg_write = 1'b1; c.result_src = 2'b01; c.retire = 1'b1; end
      S_MEMWRITE: begin c.mem_req = 1'b1; c.mem_we = 1'b1; c.addr_src = 1'b1; end
      S_EXEC_R:   begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b00; c.alu_op = 2'b10; end
      S_EXEC_I:   begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.alu_op = 2'b10; end
      S_ALUWB:    begin c.reg_write = 1'b1; c.retire = 1'b1; end
      S_BRANCH:   begin c.alu_src_a = 2'b10; c.alu_op = 2'b01; c.pc_write_cond = 1'b1;
                        c.retire = 1'b1; end
      S_JAL:      begin c.pc_write = 1'b1; c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; end
      S_LUI:      begin c.alu_src_a = 2'b11; c.alu_src_b = 2'b01; end
      default:    c = '0;
    endcase
    return c;
  endfunction

  state_e            state_q, state_d;
  ctrl_t             ctrl_q;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              illegal_q, illegal_d;
  logic              timeout_q, timeout_d;
  logic              mem_wait_s;
  logic              fetch_hit_s;
  logic              zero_unused_s;

  // The branch decision is made in the datapath from pc_write_cond and zero.
  assign zero_unused_s = zero;

  // Next-state, memory wait counting and sticky trap causes.
  always_comb begin
    state_d    = state_q;
    wait_d     = '0;
    illegal_d  = illegal_q;
    timeout_d  = timeout_q;
    mem_wait_s = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) state_d = S_DECODE;
        else           mem_wait_s = 1'b1;
      end
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADDR;
          OP_R:              state_d = S_EXEC_R;
          OP_I:              state_d = S_EXEC_I;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_LUI:            state_d = S_LUI;
          default: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADDR: begin
        if (opcode == OP_LOAD) state_d = S_MEMREAD;
        else                   state_d = S_MEMWRITE;
      end
      S_MEMREAD: begin
        if (mem_ready) state_d = S_MEMWB;
        else           mem_wait_s = 1'b1;
      end
      S_MEMWRITE: begin
        if (mem_ready) state_d = S_FETCH;
        else           mem_wait_s = 1'b1;
      end
      S_MEMWB, S_ALUWB, S_BRANCH: state_d = S_FETCH;
      S_EXEC_R, S_EXEC_I, S_JAL, S_LUI: state_d = S_ALUWB;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
    // A ready on the last allowed wait cycle never reaches this branch.
    if (mem_wait_s) begin
      if (TO_EN && (wait_q == WAIT_LAST)) begin
        state_d   = S_TRAP;
        timeout_d = 1'b1;
      end else begin
        wait_d = wait_q + WAIT_ONE;
      end
    end else begin
      wait_d = '0;
    end
  end

  // FSM state, registered control word, wait counter and sticky flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      ctrl_q    <= ctrl_of(S_FETCH);
      wait_q    <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_of(state_d);
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  // Fetch handshake completes: the only Mealy load of IR/oldPC and PC.
  assign fetch_hit_s   = reset & (state_q == S_FETCH) & mem_ready;

  assign mem_req       = reset & ctrl_q.mem_req;
  assign mem_we        = reset & ctrl_q.mem_we;
  assign addr_src      = reset & ctrl_q.addr_src;
  assign ir_write      = fetch_hit_s;
  assign pc_write      = (reset & ctrl_q.pc_write) | fetch_hit_s;
  assign pc_write_cond = reset & ctrl_q.pc_write_cond;
  assign reg_write     = reset & ctrl_q.reg_write;
  assign result_src    = reset ? ctrl_q.result_src : 2'b00;
  assign alu_src_a     = reset ? ctrl_q.alu_src_a  : 2'b00;
  assign alu_src_b     = reset ? ctrl_q.alu_src_b  : 2'b00;
  assign alu_op        = reset ? ctrl_q.alu_op     : 2'b00;
  assign retire        = reset & (ctrl_q.retire | ((state_q == S_MEMWRITE) & mem_ready));
  assign state         = state_q;
  assign illegal       = illegal_q;
  assign timeout       = timeout_q;

`ifdef MC_CTRL_PERF_EN
  localparam logic [PERF_W-1:0] PERF_ONE = PERF_W'(1);
  logic [PERF_W-1:0] cycle_cnt_q;
  logic [PERF_W-1:0] instret_cnt_q;

  // Count live (non-trap) cycles and retired instructions, wrapping freely.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      if (state_q != S_TRAP) cycle_cnt_q <= cycle_cnt_q + PERF_ONE;
      else                   cycle_cnt_q <= cycle_cnt_q;
      if (retire) instret_cnt_q <= instret_cnt_q + PERF_ONE;
      else        instret_cnt_q <= instret_cnt_q;
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Self-checking bench for riscv_multicycle_ctrl. A per-instruction plan model
// derives the expected state path and control word of every cycle from the
// opcode and the number of memory wait cycles; random instruction mixes and
// wait counts are run against it, plus directed reset, trap and timeout cases.
module tb_riscv_multicycle_ctrl;
  localparam int unsigned TO = 4;
  localparam int unsigned PW = 32;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [6:0]    opcode = 7'd0;
  logic          zero = 1'b0;
  logic          mem_ready = 1'b0;
  logic          mem_req, mem_we, addr_src, ir_write, pc_write, pc_write_cond, reg_write;
  logic [1:0]    result_src, alu_src_a, alu_src_b, alu_op;
  logic [3:0]    state;
  logic          retire, illegal, timeout;
  logic [PW-1:0] cycle_cnt, instret_cnt;

  riscv_multicycle_ctrl #(.TIMEOUT_CYCLES(TO), .PERF_W(PW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .addr_src(addr_src), .ir_write(ir_write),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .reg_write(reg_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .state(state), .retire(retire), .illegal(illegal),
    .timeout(timeout), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit m_illegal, m_timeout;
  logic [PW-1:0] m_cycles, m_instret;

  // Observed control word: {mem_req,mem_we,addr_src,ir_write,pc_write,pc_write_cond,
  // reg_write,result_src,alu_src_a,alu_src_b,alu_op,retire,illegal,timeout,state}
  logic [21:0] obs_s;
  assign obs_s = {mem_req, mem_we, addr_src, ir_write, pc_write, pc_write_cond, reg_write,
                  result_src, alu_src_a, alu_src_b, alu_op, retire, illegal, timeout, state};

  // Expected control word for one cycle spent in state st with the given mem_ready.
  function automatic logic [21:0] exp_vec(input int st, input bit rdy, input bit ill, input bit tmo);
    logic mreq, mwe, asrc, irw, pcw, pcwc, rw, ret;
    logic [1:0] res, a, b, op;
    {mreq, mwe, asrc, irw, pcw, pcwc, rw, ret} = 8'h00;
    res = 2'b00; a = 2'b00; b = 2'b00; op = 2'b00;
    case (st)
      0:  begin mreq = 1'b1; b = 2'b10; irw = rdy; pcw = rdy; end
      1:  begin a = 2'b01; b = 2'b01; end
      2:  begin a = 2'b10; b = 2'b01; end
      3:  begin mreq = 1'b1; asrc = 1'b1; end
      4:  begin rw = 1'b1; res = 2'b01; ret = 1'b1; end
      5:  begin mreq = 1'b1; mwe = 1'b1; asrc = 1'b1; ret = rdy; end
      6:  begin a = 2'b10; op = 2'b10; end
      7:  begin a = 2'b10; b = 2'b01; op = 2'b10; end
      8:  begin rw = 1'b1; ret = 1'b1; end
      9:  begin a = 2'b10; op = 2'b01; pcwc = 1'b1; ret = 1'b1; end
      10: begin pcw = 1'b1; a = 2'b01; b = 2'b10; end
      11: begin a = 2'b11; b = 2'b01; end
      default: ;
    endcase
    return {mreq, mwe, asrc, irw, pcw, pcwc, rw, res, a, b, op, ret, ill, tmo, 4'(st)};
  endfunction

  function automatic bit rnd();
    return 1'($urandom);
  endfunction

  // One clock cycle expected in state st; checks control word and counters.
  task automatic cyc(input int st, input bit rdy);
    logic [21:0] e;
    logic [PW-1:0] ec, ei;
    mem_ready = rdy;
    zero = rnd();
    @(negedge clk);
    e = exp_vec(st, rdy, m_illegal, m_timeout);
`ifdef MC_CTRL_PERF_EN
    ec = m_cycles; ei = m_instret;
`else
    ec = '0; ei = '0;
`endif
    checks++;
    assert (obs_s === e) else begin
      errors++; $error("FAIL ctrl_st%0d observed=%h expected=%h", st, obs_s, e);
    end
    checks++;
    assert (cycle_cnt === ec) else begin
      errors++; $error("FAIL cycle_cnt observed=%0d expected=%0d", cycle_cnt, ec);
    end
    checks++;
    assert (instret_cnt === ei) else begin
      errors++; $error("FAIL instret_cnt observed=%0d expected=%0d", instret_cnt, ei);
    end
    if (st != 12) m_cycles++;
    if (e[6]) m_instret++;   // bit 6 is the retire position
    @(posedge clk);
    #1;
  endtask

  // A memory-handshake state: 'waits' not-ready cycles then ready, or timeout.
  task automatic mem_phase(input int st, input int waits, output bit ok);
    ok = 1'b0;
    for (int n = 0; n <= waits; n++) begin
      if (n == TO) begin
        m_timeout = 1'b1;
        return;
      end
      if (n == waits) begin
        cyc(st, 1'b1);
        ok = 1'b1;
      end else begin
        cyc(st, 1'b0);
      end
    end
  endtask

  // One instruction from fetch to retire (or into the trap state).
  task automatic run_instr(input logic [6:0] op, input int fw, input int mw);
    bit ok;
    opcode = op;
    mem_phase(0, fw, ok);
    if (ok) begin
      cyc(1, rnd());
      case (op)
        OP_LOAD:   begin cyc(2, rnd()); mem_phase(3, mw, ok); if (ok) cyc(4, rnd()); end
        OP_STORE:  begin cyc(2, rnd()); mem_phase(5, mw, ok); end
        OP_R:      begin cyc(6, rnd()); cyc(8, rnd()); end
        OP_I:      begin cyc(7, rnd()); cyc(8, rnd()); end
        OP_BRANCH: cyc(9, rnd());
        OP_JAL:    begin cyc(10, rnd()); cyc(8, rnd()); end
        OP_LUI:    begin cyc(11, rnd()); cyc(8, rnd()); end
        default:   begin m_illegal = 1'b1; ok = 1'b0; end
      endcase
    end
    if (!ok) begin
      repeat (3) cyc(12, rnd());
    end
  endtask

  // Asynchronous reset: everything must drop at once, then restart at FETCH.
  task automatic do_reset();
    reset = 1'b0;
    mem_ready = 1'b1;
    #1;
    checks++;
    assert (obs_s === 22'h0) else begin
      errors++; $error("FAIL reset_outputs observed=%h expected=%h", obs_s, 22'h0);
    end
    checks++;
    assert ({cycle_cnt, instret_cnt} === {PW{2'b00}}) else begin
      errors++; $error("FAIL reset_counters observed=%0d/%0d expected=0/0", cycle_cnt, instret_cnt);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    assert (obs_s === 22'h0) else begin
      errors++; $error("FAIL reset_held observed=%h expected=%h", obs_s, 22'h0);
    end
    reset = 1'b1;
    m_illegal = 1'b0; m_timeout = 1'b0; m_cycles = '0; m_instret = '0;
  endtask

  function automatic logic [6:0] legal_op(input int k);
    case (k)
      0: return OP_R;
      1: return OP_I;
      2: return OP_LOAD;
      3: return OP_STORE;
      4: return OP_BRANCH;
      5: return OP_JAL;
      default: return OP_LUI;
    endcase
  endfunction

  initial begin
    m_illegal = 1'b0; m_timeout = 1'b0; m_cycles = '0; m_instret = '0;
    do_reset();
    // Directed: ADD, LW with three waits, BEQ twice, JAL, SW, ADDI, LUI.
    run_instr(OP_R, 0, 0);
    run_instr(OP_LOAD, 0, 3);
    run_instr(OP_BRANCH, 0, 0);
    run_instr(OP_BRANCH, 0, 0);
    run_instr(OP_JAL, 0, 0);
    run_instr(OP_STORE, 2, 1);
    run_instr(OP_I, 1, 0);
    run_instr(OP_LUI, 3, 0);
    // Randomized mix; waits stay within the timeout window (3 = last allowed cycle).
    for (int i = 0; i < 60; i++) begin
      run_instr(legal_op(int'($urandom_range(0, 6))),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
    // Reset in the middle of a load: no retire is counted.
    opcode = OP_LOAD;
    cyc(0, 1'b1); cyc(1, rnd()); cyc(2, rnd()); cyc(3, 1'b0);
    do_reset();
    run_instr(OP_R, 0, 0);
    // Illegal opcode traps after decode and stays until reset.
    run_instr(7'b1111111, 0, 0);
    do_reset();
    run_instr(OP_I, 0, 0);
    // Fetch that never completes: timeout after TO wait cycles, counters frozen.
    run_instr(OP_R, TO, 0);
    do_reset();
    // Store that never completes in MEMWRITE.
    run_instr(OP_STORE, 0, TO);
    do_reset();
    for (int i = 0; i < 20; i++) begin
      run_instr(legal_op(int'($urandom_range(0, 6))),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
